// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer: widths, shifter op encoding, FSM states.
package shift_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned AMT_W  = 4;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] SH_PASS = 2'b00;
    localparam logic [OP_W-1:0] SH_LSL  = 2'b01;
    localparam logic [OP_W-1:0] SH_LSR  = 2'b10;
    localparam logic [OP_W-1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step 16-bit shifter: pass, logical left, logical right, arithmetic right by one bit.
module shifter
    import shift_pkg::*;
(
    input  logic [OP_W-1:0]   shift,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] sout
);

    always_comb begin
        sout = in;
        case (shift)
            SH_LSL:  sout = {in[DATA_W-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[DATA_W-1:1]};
            SH_ASR:  sout = {in[DATA_W-1], in[DATA_W-1:1]};
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-step shift controller: accepts one request, iterates the one-bit shifter
// amt times on the accumulator, then offers the result on a valid/ready port.
module shift_sequencer
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OP_W-1:0]   in_op,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [AMT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [OP_W-1:0]     sh_op_c;
    logic [DATA_W-1:0]   step_c;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                busy_q, busy_d;

    shifter u_shifter (
        .shift (sh_op_c),
        .in    (acc_q),
        .sout  (step_c)
    );

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sh_op_c = SH_PASS;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d = in_data;
                    op_d  = in_op;
                    cnt_d = in_amt;
                    if ((in_amt == AMT_W'(0)) || (in_op == SH_PASS)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                sh_op_c = op_q;
                acc_d   = step_c;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        out_data_d  = acc_d;
    end

    // State and output registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= SH_PASS;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed corner cases plus random back-to-back traffic.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic [1:0]  in_op = 2'b00;
    logic [3:0]  in_amt = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int n_abort = 0;
    bit rnd_done = 1'b0;

    typedef struct {
        logic [15:0] data;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [15:0] prev_d = 16'h0;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                              input logic [3:0] amt);
        logic [15:0] r;
        case (op)
            2'b01:   r = d << amt;
            2'b10:   r = d >> amt;
            2'b11:   r = 16'($signed(d) >>> amt);
            default: r = d;
        endcase
        return r;
    endfunction

    // Monitor: push on accept, check latency/stability, pop on output handshake
    always @(negedge clk) begin
        if (reset) begin
            n_abort += sb.size();
            sb.delete();
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) check("valid_without_request", 32'(out_valid), 32'd0);
                else check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            end
            if (out_valid && prev_v && !prev_r) check("hold_data", 32'(out_data), 32'(prev_d));
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    check("data", 32'(out_data), 32'(sb[0].data));
                    void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.data    = ref_shift(in_data, in_op, in_amt);
                e.acc_cyc = cyc;
                e.lat     = (in_op == 2'b00 || in_amt == 4'd0) ? 1 : int'(in_amt) + 1;
                sb.push_back(e);
                n_acc++;
            end
            check("busy_vs_ready", 32'(busy), 32'(!in_ready));
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] op, input logic [3:0] amt);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_amt   = amt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Directed shifts with consumer always ready
        out_ready = 1'b1;
        send(16'h0001, 2'b01, 4'd15);
        drain();
        send(16'h8000, 2'b11, 4'd4);
        drain();
        send(16'h8000, 2'b10, 4'd4);
        drain();
        send(16'hA5A5, 2'b01, 4'd0);
        drain();
        send(16'hA5A5, 2'b00, 4'd7);
        drain();
        check("directed_count", 32'(n_out), 32'd5);

        // Backpressure in DONE with stray requests
        out_ready = 1'b0;
        send(16'h1234, 2'b10, 4'd3);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check("bp_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_op    = 2'b01;
            in_amt   = 4'd1;
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h0246);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_after", 32'(in_ready), 32'd1);
        check("bp_valid_after", 32'(out_valid), 32'd0);
        check("bp_one_handoff", 32'(n_out), 32'd6);

        // Reset in the middle of a SHIFT sequence
        send(16'h0003, 2'b01, 4'd10);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_output", 32'(n_out), 32'd6);
        send(16'h0003, 2'b01, 4'd10);
        drain();
        check("post_abort_count", 32'(n_out), 32'd7);

        // Random back-to-back traffic with gaps on both sides
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    send(16'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("no_drop_dup", 32'(n_out), 32'(n_acc - n_abort));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
